// File: rtl/integrator_back.sv
// Backward-Euler integrator y[n] = sat(y[n-1] + x[n]), updated once per CLK_I rise.
// Everything runs on MCLK_I; CLK_O is CLK_I re-timed so DATA_O is settled before it rises.
module integrator_back #(
    parameter int DATA_BIT_WIDTH = 5,
    parameter bit SAT_EN         = 1'b1
) (
    input  logic                      MCLK_I,
    input  logic                      RST_I,
    input  logic                      CLK_I,
    input  logic [DATA_BIT_WIDTH-1:0] DATA_I,
    output logic                      CLK_O,
    output logic [DATA_BIT_WIDTH-1:0] DATA_O,
    output logic                      OFDET_O,
    output logic                      UFDET_O
);
    localparam int W = DATA_BIT_WIDTH;
    localparam logic signed [W:0] MAX_V = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] MIN_V = {2'b11, {(W-1){1'b0}}};

    logic signed [W-1:0] acc;
    logic signed [W:0]   sum_p0;
    logic                clk_d;
    logic                rise_p0;
    logic                c1;
    logic                c2;

    function automatic logic signed [W-1:0] limit(input logic signed [W:0] s);
        if (SAT_EN && (s > MAX_V)) return MAX_V[W-1:0];
        if (SAT_EN && (s < MIN_V)) return MIN_V[W-1:0];
        return s[W-1:0];
    endfunction

    // Stage p0: edge detect and one-bit-wider sum, so the add itself never wraps
    assign rise_p0 = CLK_I & ~clk_d;
    assign sum_p0  = {acc[W-1], acc} + {DATA_I[W-1], DATA_I};

    always_ff @(posedge MCLK_I) begin
        if (RST_I) begin
            acc     <= '0;
            OFDET_O <= 1'b0;
            UFDET_O <= 1'b0;
            clk_d   <= 1'b1;  // a CLK_I already high at release is not an edge
            c1      <= 1'b0;
            c2      <= 1'b0;
        end else begin
            clk_d <= CLK_I;
            c1    <= CLK_I;
            c2    <= c1;
            if (rise_p0) begin
                acc     <= limit(sum_p0);
                OFDET_O <= (sum_p0 > MAX_V);
                UFDET_O <= (sum_p0 < MIN_V);
            end
        end
    end

    // Outputs: all straight from registers
    assign DATA_O = acc;
    assign CLK_O  = c2;
endmodule

// File: tb/tb_integrator_back.sv
// Scoreboard bench for integrator_back: saturating and wrapping instances share one stimulus stream.
`timescale 1ns/1ps
module tb_integrator_back;
    localparam int W = 5;

    logic         mclk = 1'b0;
    logic         rst = 1'b0;
    logic         clk_i = 1'b0;
    logic [W-1:0] data_i = '0;
    logic         clk_o_s, of_s, uf_s, clk_o_w, of_w, uf_w;
    logic [W-1:0] data_s, data_w;
    int           cyc = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] ds;
        logic [W-1:0] dw;
        logic ofs, ufs, ofw, ufw;
        int edge_k;
    } item_t;
    item_t q[$];

    integrator_back #(.DATA_BIT_WIDTH(W), .SAT_EN(1'b1)) dut_sat (
        .MCLK_I(mclk), .RST_I(rst), .CLK_I(clk_i), .DATA_I(data_i),
        .CLK_O(clk_o_s), .DATA_O(data_s), .OFDET_O(of_s), .UFDET_O(uf_s)
    );

    integrator_back #(.DATA_BIT_WIDTH(W), .SAT_EN(1'b0)) dut_wrap (
        .MCLK_I(mclk), .RST_I(rst), .CLK_I(clk_i), .DATA_I(data_i),
        .CLK_O(clk_o_w), .DATA_O(data_w), .OFDET_O(of_w), .UFDET_O(uf_w)
    );

    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: a CLK_O rise means one sample is presented downstream
    logic         prev_clko = 1'b0;
    logic [W-1:0] prev_ds = '0, prev_dw = '0, last_s = '0, last_w = '0;
    always @(negedge mclk) begin
        item_t it;
        if (rst) begin
            last_s = '0;
            last_w = '0;
        end else if (clk_o_s && !prev_clko) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_clk_o: CLK_O rose at cycle %0d with no pending sample", cyc);
            end else begin
                it = q.pop_front();
                chk("latency_clk_o", cyc, it.edge_k + 1);
                chk("data_sat", $signed(data_s), $signed(it.ds));
                chk("data_sat_at_k", $signed(prev_ds), $signed(it.ds));
                chk("of_sat", of_s, it.ofs);
                chk("uf_sat", uf_s, it.ufs);
                chk("clk_o_wrap", clk_o_w, 1);
                chk("data_wrap", $signed(data_w), $signed(it.dw));
                chk("data_wrap_at_k", $signed(prev_dw), $signed(it.dw));
                chk("of_wrap", of_w, it.ofw);
                chk("uf_wrap", uf_w, it.ufw);
                if (!it.ofs && !it.ufs)
                    chk("cascade_diff_sat", $signed(data_s - last_s), $signed(it.x));
                chk("cascade_diff_wrap", $signed(data_w - last_w), $signed(it.x));
                last_s = data_s;
                last_w = data_w;
            end
        end
        prev_clko = clk_o_s;
        prev_ds   = data_s;
        prev_dw   = data_w;
    end

    task automatic do_reset(input int n);
        @(posedge mclk);
        #1 rst = 1'b1;
        repeat (n) @(posedge mclk);
        #1 rst = 1'b0;
    endtask

    // One sample: CLK_I high for h cycles then low for h cycles (unless left high)
    task automatic send(input int x, input int ds, input bit ofs, input bit ufs,
                        input int dw, input bit ofw, input bit ufw,
                        input int h, input bit leave_high);
        item_t it;
        @(posedge mclk);
        #1;
        clk_i     = 1'b1;
        data_i    = W'(x);
        it.x      = W'(x);
        it.ds     = W'(ds);
        it.dw     = W'(dw);
        it.ofs    = ofs;
        it.ufs    = ufs;
        it.ofw    = ofw;
        it.ufw    = ufw;
        it.edge_k = cyc + 1;
        q.push_back(it);
        if (!leave_high) begin
            repeat (h) @(posedge mclk);
            #1 clk_i = 1'b0;
            repeat (h - 1) @(posedge mclk);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(posedge mclk);
            t++;
        end
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d samples never produced a CLK_O rise", q.size());
            q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        item_t sp;

        do_reset(3);
        chk("rst_data_sat", $signed(data_s), 0);
        chk("rst_of_sat", of_s, 0);
        chk("rst_uf_sat", uf_s, 0);
        chk("rst_clk_o", clk_o_s, 0);
        chk("rst_data_wrap", $signed(data_w), 0);

        // Count up to the positive limit and one past it
        for (int i = 1; i <= 16; i++)
            send(1, (i <= 15) ? i : 15, i == 16, 1'b0, (i <= 15) ? i : -16, i == 16, 1'b0, 2, 1'b0);
        // Zero input clears the flags
        send(0, 15, 1'b0, 1'b0, -16, 1'b0, 1'b0, 2, 1'b0);
        // Count down to the negative limit and one past it
        for (int k = 1; k <= 32; k++)
            send(-1, (k <= 31) ? 15 - k : -16, 1'b0, k == 32, 16 - k, 1'b0, k == 1, 2, 1'b0);
        drain();

        // Reset pulse while CLK_I is held high
        do_reset(2);
        for (int i = 1; i <= 6; i++)
            send(1, i, 1'b0, 1'b0, i, 1'b0, 1'b0, 2, 1'b0);
        send(1, 7, 1'b0, 1'b0, 7, 1'b0, 1'b0, 2, 1'b1);
        repeat (4) @(posedge mclk);
        #1 rst = 1'b1;
        @(posedge mclk);
        #1 rst = 1'b0;
        chk("pulse_data_sat", $signed(data_s), 0);
        chk("pulse_of_sat", of_s, 0);
        chk("pulse_uf_sat", uf_s, 0);
        chk("pulse_clk_o", clk_o_s, 0);
        chk("pulse_data_wrap", $signed(data_w), 0);
        // CLK_O re-rises from the held CLK_I; the accumulator must stay at 0
        sp.x = '0; sp.ds = '0; sp.dw = '0;
        sp.ofs = 1'b0; sp.ufs = 1'b0; sp.ofw = 1'b0; sp.ufw = 1'b0;
        sp.edge_k = cyc + 1;
        q.push_back(sp);
        repeat (3) @(posedge mclk);
        #1 clk_i = 1'b0;
        repeat (2) @(posedge mclk);
        send(3, 3, 1'b0, 1'b0, 3, 1'b0, 1'b0, 2, 1'b0);
        drain();

        // Latency at a 64-cycle sample period: acc walks 7, 14, 7, 0
        do_reset(2);
        for (int i = 0; i < 100; i++) begin
            int e;
            case (i % 4)
                0: e = 7;
                1: e = 14;
                2: e = 7;
                default: e = 0;
            endcase
            send(((i % 4) < 2) ? 7 : -7, e, 1'b0, 1'b0, e, 1'b0, 1'b0, 32, 1'b0);
        end
        drain();

        // Cascade stream: 64 x (+1) then 64 x (-1)
        do_reset(2);
        for (int i = 1; i <= 64; i++)
            send(1, (i <= 15) ? i : 15, i > 15, 1'b0, i, (i % 32) == 16, 1'b0, 2, 1'b0);
        for (int j = 1; j <= 64; j++)
            send(-1, (j <= 31) ? 15 - j : -16, 1'b0, j > 31, -j, 1'b0, ((j - 1) % 32) == 16, 2, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
